// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and op-class helper for the execute unit.
package alu_pkg;

  localparam logic [4:0] ALU_ADD    = 5'h00;
  localparam logic [4:0] ALU_SUB    = 5'h01;
  localparam logic [4:0] ALU_XOR    = 5'h02;
  localparam logic [4:0] ALU_OR     = 5'h03;
  localparam logic [4:0] ALU_AND    = 5'h04;
  localparam logic [4:0] ALU_SLL    = 5'h05;
  localparam logic [4:0] ALU_SRL    = 5'h06;
  localparam logic [4:0] ALU_SRA    = 5'h07;
  localparam logic [4:0] ALU_SLT    = 5'h08;
  localparam logic [4:0] ALU_SLTU   = 5'h09;
  localparam logic [4:0] ALU_MUL    = 5'h10;
  localparam logic [4:0] ALU_MULH   = 5'h11;
  localparam logic [4:0] ALU_MULHSU = 5'h12;
  localparam logic [4:0] ALU_MULHU  = 5'h13;
  localparam logic [4:0] ALU_DIV    = 5'h14;
  localparam logic [4:0] ALU_DIVU   = 5'h15;
  localparam logic [4:0] ALU_REM    = 5'h16;
  localparam logic [4:0] ALU_REMU   = 5'h17;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ITER,
    ST_FIX,
    ST_DONE
  } state_t;

  // mul/div ops occupy 0x10-0x17
  function automatic logic is_muldiv(input logic [4:0] op);
    return op[4:3] == 2'b10;
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// One-bit-per-cycle magnitude multiplier / restoring divider with sign and
// special-case correction applied combinationally on the final registers.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [4:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done,
  output logic [W-1:0] res
);

  localparam int CW = $clog2(W);

  logic [4:0]    op_q;
  logic [W-1:0]  hi, lo, d, a_q;
  logic [CW-1:0] cnt;
  logic          running, neg, neg_rem, div0, ovf;

  logic          a_sgn, b_sgn;
  logic [W-1:0]  a_mag, b_mag;
  logic [W:0]    add_sum, trial;
  logic [2*W-1:0] prod, prod_fix;
  logic [W-1:0]  q_fix, r_fix;

  always_comb begin
    a_sgn = a[W-1] && (op == ALU_MULH || op == ALU_MULHSU || op == ALU_DIV || op == ALU_REM);
    b_sgn = b[W-1] && (op == ALU_MULH || op == ALU_DIV || op == ALU_REM);
    a_mag = a_sgn ? -a : a;
    b_mag = b_sgn ? -b : b;
  end

  // hi:lo doubles as product accumulator (mul) and remainder:dividend (div)
  assign add_sum = {1'b0, hi} + (lo[0] ? {1'b0, d} : {(W+1){1'b0}});
  assign trial   = {hi, lo[W-1]} - {1'b0, d};
  assign done    = running && (cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q    <= '0;
      hi      <= '0;
      lo      <= '0;
      d       <= '0;
      a_q     <= '0;
      cnt     <= '0;
      running <= 1'b0;
      neg     <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
      ovf     <= 1'b0;
    end else if (start) begin
      op_q    <= op;
      hi      <= '0;
      lo      <= op[2] ? a_mag : b_mag;
      d       <= op[2] ? b_mag : a_mag;
      a_q     <= a;
      cnt     <= CW'(W - 1);
      running <= 1'b1;
      neg     <= a_sgn ^ b_sgn;
      neg_rem <= a_sgn;
      div0    <= (b == '0);
      ovf     <= (op == ALU_DIV || op == ALU_REM) &&
                 (a == {1'b1, {(W-1){1'b0}}}) && (b == '1);
    end else if (running) begin
      if (!op_q[2]) begin
        hi <= add_sum[W:1];
        lo <= {add_sum[0], lo[W-1:1]};
      end else if (!trial[W]) begin
        hi <= trial[W-1:0];
        lo <= {lo[W-2:0], 1'b1};
      end else begin
        hi <= {hi[W-2:0], lo[W-1]};
        lo <= {lo[W-2:0], 1'b0};
      end
      if (cnt == '0) running <= 1'b0;
      else           cnt     <= cnt - 1'b1;
    end
  end

  always_comb begin
    prod     = {hi, lo};
    prod_fix = neg ? -prod : prod;
    q_fix    = neg ? -lo : lo;
    r_fix    = neg_rem ? -hi : hi;
    res      = '0;
    case (op_q)
      ALU_MUL:                          res = prod_fix[W-1:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU:  res = prod_fix[2*W-1:W];
      ALU_DIV, ALU_DIVU:
        res = div0 ? '1 : (ovf ? {1'b1, {(W-1){1'b0}}} : q_fix);
      ALU_REM, ALU_REMU:
        res = div0 ? a_q : (ovf ? '0 : r_fix);
      default:                          res = '0;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Handshaked EX-stage unit: single-cycle base ALU inline, RV32M ops delegated
// to the iterative datapath, results and flags held until consumed.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int OPERAND_WIDTH = 32,
  parameter int SHAMT_WIDTH   = $clog2(OPERAND_WIDTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               aluOP,
  input  logic [OPERAND_WIDTH-1:0] operand1,
  input  logic [OPERAND_WIDTH-1:0] operand2,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OPERAND_WIDTH-1:0] result,
  output logic [2:0]               flags,
  output logic                     busy
);

  localparam int W = OPERAND_WIDTH;

  state_t               state, state_n;
  logic                 accept, md_start, md_done;
  logic [W-1:0]         md_res, base_res;
  logic [2:0]           flag_calc, flags_hold;
  logic [SHAMT_WIDTH-1:0] shamt;

  assign in_ready  = (state == ST_IDLE);
  assign busy      = (state == ST_ITER);
  assign out_valid = (state == ST_DONE);
  assign accept    = in_valid && in_ready;
  assign md_start  = accept && is_muldiv(aluOP);
  assign shamt     = operand2[SHAMT_WIDTH-1:0];

  assign flag_calc = {operand1 == operand2, operand1 < operand2,
                      $signed(operand1) < $signed(operand2)};

  always_comb begin
    base_res = '0;
    case (aluOP)
      ALU_ADD:  base_res = operand1 + operand2;
      ALU_SUB:  base_res = operand1 - operand2;
      ALU_XOR:  base_res = operand1 ^ operand2;
      ALU_OR:   base_res = operand1 | operand2;
      ALU_AND:  base_res = operand1 & operand2;
      ALU_SLL:  base_res = operand1 << shamt;
      ALU_SRL:  base_res = operand1 >> shamt;
      ALU_SRA:  base_res = $unsigned($signed(operand1) >>> shamt);
      ALU_SLT:  base_res = {{(W-1){1'b0}}, flag_calc[0]};
      ALU_SLTU: base_res = {{(W-1){1'b0}}, flag_calc[1]};
      default:  base_res = '0;
    endcase
  end

  alu_muldiv_iter #(.W(W)) u_muldiv (
    .clk   (clk),
    .reset (reset),
    .start (md_start),
    .op    (aluOP),
    .a     (operand1),
    .b     (operand2),
    .done  (md_done),
    .res   (md_res)
  );

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (accept) state_n = is_muldiv(aluOP) ? ST_ITER : ST_DONE;
      ST_ITER: if (md_done) state_n = ST_FIX;
      ST_FIX:  state_n = ST_DONE;
      ST_DONE: if (out_ready) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // flags of a mul/div op are parked until its result lands in FIX
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      result     <= '0;
      flags      <= '0;
      flags_hold <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        if (is_muldiv(aluOP)) begin
          flags_hold <= flag_calc;
        end else begin
          result <= base_res;
          flags  <= flag_calc;
        end
      end
      if (state == ST_FIX) begin
        result <= md_res;
        flags  <= flags_hold;
      end
    end
  end

endmodule
